// File: rtl/led_pwm_bank_if.sv
// rtl/led_pwm_bank_if.sv - one-cycle channel configuration write port
`timescale 1ns/1ps
interface led_pwm_bank_if #(
    parameter int CH_W  = 2,
    parameter int PWM_W = 8
);
    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic [1:0]       cfg_mode;
    logic [PWM_W-1:0] cfg_duty;

    modport master (output cfg_we, output cfg_ch, output cfg_mode, output cfg_duty);
    modport slave  (input  cfg_we, input  cfg_ch, input  cfg_mode, input  cfg_duty);
endinterface

// File: rtl/led_pwm_bank.sv
// rtl/led_pwm_bank.sv - multi-channel LED driver with off/on/PWM/blink modes
`timescale 1ns/1ps
module led_pwm_bank #(
    parameter int              N_CH     = 3,
    parameter int              PWM_W    = 8,
    parameter int              PRESC    = 47,
    parameter int              BLINK_W  = 8,
    parameter logic [N_CH-1:0] INV_MASK = N_CH'(3'b010),
    parameter int              CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk_12m,
    input  logic            rst_n,
    led_pwm_bank_if.slave   cfg,
    output logic [N_CH-1:0] led,
    output logic            period_start
);
    localparam int                 PRESC_W   = (PRESC > 0) ? $clog2(PRESC + 1) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESC);

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_ON    = 2'b01;
    localparam logic [1:0] MODE_PWM   = 2'b10;
    localparam logic [1:0] MODE_BLINK = 2'b11;

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PWM_W-1:0]   pwm_q, pwm_d;
    logic [BLINK_W-1:0] blink_q, blink_d;
    logic [1:0]         mode_p_q [N_CH];
    logic [1:0]         mode_p_d [N_CH];
    logic [1:0]         mode_a_q [N_CH];
    logic [1:0]         mode_a_d [N_CH];
    logic [PWM_W-1:0]   duty_p_q [N_CH];
    logic [PWM_W-1:0]   duty_p_d [N_CH];
    logic [PWM_W-1:0]   duty_a_q [N_CH];
    logic [PWM_W-1:0]   duty_a_d [N_CH];
    logic [N_CH-1:0]    led_q, led_d;
    logic               period_start_q;
    logic               tick, wrap, blink_off, wr_valid;

    assign tick      = (presc_q == PRESC_MAX);
    assign wrap      = tick && (pwm_q == '1);
    assign blink_off = blink_q[BLINK_W-1];
    assign wr_valid  = cfg.cfg_we && (32'(cfg.cfg_ch) < 32'(N_CH));

    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        pwm_d   = tick ? pwm_q + 1'b1 : pwm_q;
        blink_d = wrap ? blink_q + 1'b1 : blink_q;
        led_d   = INV_MASK;
        for (int i = 0; i < N_CH; i++) begin
            mode_p_d[i] = mode_p_q[i];
            duty_p_d[i] = duty_p_q[i];
            if (wr_valid && (cfg.cfg_ch == CH_W'(i))) begin
                mode_p_d[i] = cfg.cfg_mode;
                duty_p_d[i] = cfg.cfg_duty;
            end
            // Active loads from the next pending value so a write on the wrap edge is not lost.
            mode_a_d[i] = wrap ? mode_p_d[i] : mode_a_q[i];
            duty_a_d[i] = wrap ? duty_p_d[i] : duty_a_q[i];
            case (mode_a_q[i])
                MODE_OFF:   led_d[i] = INV_MASK[i];
                MODE_ON:    led_d[i] = ~INV_MASK[i];
                MODE_PWM:   led_d[i] = (pwm_q < duty_a_q[i]) ^ INV_MASK[i];
                MODE_BLINK: led_d[i] = (!blink_off && (pwm_q < duty_a_q[i])) ^ INV_MASK[i];
            endcase
        end
    end

    always_ff @(posedge clk_12m or negedge rst_n) begin
        if (!rst_n) begin
            presc_q        <= '0;
            pwm_q          <= '0;
            blink_q        <= '0;
            led_q          <= INV_MASK;
            period_start_q <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                mode_p_q[i] <= MODE_OFF;
                mode_a_q[i] <= MODE_OFF;
                duty_p_q[i] <= '0;
                duty_a_q[i] <= '0;
            end
        end else begin
            presc_q        <= presc_d;
            pwm_q          <= pwm_d;
            blink_q        <= blink_d;
            led_q          <= led_d;
            period_start_q <= wrap;
            mode_p_q       <= mode_p_d;
            mode_a_q       <= mode_a_d;
            duty_p_q       <= duty_p_d;
            duty_a_q       <= duty_a_d;
        end
    end

    assign led          = led_q;
    assign period_start = period_start_q;
endmodule

// File: doc/led_pwm_bank.md
# led_pwm_bank

Parametrised multi-channel LED driver for the 12 MHz board clock. It replaces direct counter-bit LED wiring with per-channel off/on/PWM/blink control. A shared prescaler and period counter drive all channels. Per-channel configuration is written through a one-cycle write port and takes effect glitch-free at the next PWM period boundary.

## Interface
- N_CH, 3, number of LED channels (1..16)
- PWM_W, 8, PWM counter and duty width; period = 2^PWM_W ticks
- PRESC, 47, tick every PRESC+1 clocks (47 gives a 250 kHz tick and a ~977 Hz period at PWM_W=8)
- BLINK_W, 8, blink counter width; blink half-period = 2^(BLINK_W-1) PWM periods
- INV_MASK, 3'b010, N_CH bits; bit i=1 makes led[i] active-low
- CH_W, derived, max(1, clog2(N_CH))

Ports:
- clk_12m  in  1  system clock, 12 MHz
- rst_n  in  1  reset, asynchronous assert, active-low
- cfg_we  in  1  config write strobe, one cycle
- cfg_ch  in  CH_W  target channel; values >= N_CH are ignored
- cfg_mode  in  2  00 off, 01 on, 10 pwm, 11 blink
- cfg_duty  in  PWM_W  duty value
- led  out  N_CH  LED pins, registered
- period_start  out  1  one-cycle pulse marking the first clock of each PWM period

## Operation
- presc: counts 0..PRESC, then wraps to 0. tick = (presc==PRESC).
- pwm_cnt: PWM_W bits, increments on tick, wraps from 2^PWM_W-1 to 0. wrap = tick && pwm_cnt==all-ones.
- blink_cnt: BLINK_W bits, increments on wrap, wraps naturally. blink_off = blink_cnt[BLINK_W-1].
- Per channel there are pending regs (mode_p, duty_p) and active regs (mode_a, duty_a).
- cfg_we with a valid cfg_ch writes that channel's pending regs at that edge. Other channels are unaffected.
- On a wrap edge, every channel loads active from pending.
- If cfg_we coincides with wrap, the written values go to both pending and active for that channel at that edge (bypass, no lost update).
- Raw on-condition per channel i:
  - off: 0
  - on: 1
  - pwm: pwm_cnt < duty_a (unsigned). duty 0 is never on; all-ones is on for 2^PWM_W-1 of 2^PWM_W ticks.
  - blink: !blink_off && (pwm_cnt < duty_a)
- led[i] <= raw_i ^ INV_MASK[i], registered every clock.
- period_start <= wrap, registered. It is high exactly in the cycle where pwm_cnt==0 and presc==0.

## Timing
- Reset (rst_n low, async): presc, pwm_cnt and blink_cnt = 0. All pending/active mode = off, duty = 0. led = INV_MASK (all channels at the off level). period_start = 0.
- Reset release: the first tick occurs PRESC+1 clocks after the first active edge.
- Output latency: led reflects pwm_cnt/active state one clock after the edge where they change.
- Config latency: a write at edge k (not a wrap edge) affects led from the clock after the next wrap edge. The current period is always completed with the old settings.
- A write followed by a second write to the same channel before the wrap: the last write wins.
- Writes to different channels in consecutive cycles: all are applied at the same wrap.
- Reset mid-period: all state is cleared immediately, and pending writes are discarded.
- Blink period with defaults: 2^BLINK_W periods of 2^PWM_W*(PRESC+1) clocks (~262 ms).

## Test plan
- Reset: hold rst_n low with default params -> led=3'b010, period_start=0. Assert rst_n asynchronously mid-run -> led returns to 3'b010 without waiting for a clock edge.
- PWM duty (PRESC=0, PWM_W=4): write ch0 pwm duty=4 -> from the period after the next wrap, led[0] is high 4 cycles then low 12, repeating. period_start pulses every 16 cycles.
- Edge duties (PRESC=0, PWM_W=4): duty 0 -> led[0] constantly 0. duty 15 -> high 15 of 16 cycles. Mode on -> constant 1. ch1 with mode on -> led[1]=0 (inverted).
- Glitch-free update (PRESC=0, PWM_W=4): change duty 4->12 at pwm_cnt=2 -> current period keeps its 4-high pattern, next period is 12-high. Write coinciding with the wrap edge -> new duty is used in the immediately following period.
- Blink (PRESC=0, PWM_W=2, BLINK_W=2): ch2 blink duty=3 -> 2 periods of 3/4 PWM, then 2 periods fully off, repeating every 16 cycles.
- Invalid channel: N_CH=3, cfg_ch=3 with mode on -> no led changes, and the pending state of all channels is unchanged.
